decode_stage: RTL and testbench

Parametrised instruction-decode pipeline stage for the single-issue RISC-V core, sitting between fetch and execute. It holds the architectural register file with write-through bypass, generates immediates for every RV32I format, and selects write-back data from the raw sources. It registers all decoded operands into an ID/EX pipeline register with valid/ready handshakes, a one-bubble load-use interlock, a flush input, and a stall counter.

---
 rtl/decode_stage.sv | 225 ++++++++++++++++++++++
 tb/tb_decode_stage.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: RV32I instruction-decode stage between fetch and execute.
//
// Holds the architectural register file (with same-cycle write-through
// bypass), generates the immediate for every base-ISA format, selects the
// write-back data and registers the decoded operands into an ID/EX register
// with a valid/ready handshake, a one-bubble load-use interlock, a flush and
// a load-use stall counter.
//
// Ports
//   clk, rstn          core clock, asynchronous active-low reset
//   in_valid/in_ready  fetch handshake for inst/pc
//   inst, pc           instruction word and its address
//   wb_en/wb_addr      register-file write port
//   wb_sel             write data select: 00 alu, 01 mem, 10 pc+4, 11 imm
//   wb_alu/mem/pc4/imm write-back data sources
//   ex_ready           execute accepts out_* this cycle
//   flush              drop the held and the incoming instruction
//   out_*              registered decoded operands and fields
//   stall_cnt          number of load-use bubbles inserted (wraps)

// One register-file read port: x0 reads zero, a same-cycle write to the
// addressed register is forwarded ahead of the array contents.
module decode_stage_rdport #(
  parameter int XLEN      = 32,
  parameter int REG_COUNT = 32,
  parameter int AW        = $clog2(REG_COUNT)
) (
  input  logic [REG_COUNT-1:0][XLEN-1:0] i_rf,
  input  logic [AW-1:0]                  i_rs,
  input  logic                           i_wb_en,
  input  logic [AW-1:0]                  i_wb_addr,
  input  logic [XLEN-1:0]                i_wb_data,
  output logic [XLEN-1:0]                o_rdata
);
  always_comb begin
    o_rdata = i_rf[i_rs];
    if (i_rs == '0)                              o_rdata = '0;
    else if (i_wb_en && (i_wb_addr == i_rs))     o_rdata = i_wb_data;
  end
endmodule

module decode_stage #(
  parameter  int XLEN      = 32,
  parameter  int REG_COUNT = 32,
  localparam int AW        = $clog2(REG_COUNT)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [1:0]      wb_sel,
  input  logic [XLEN-1:0] wb_alu,
  input  logic [XLEN-1:0] wb_mem,
  input  logic [XLEN-1:0] wb_pc4,
  input  logic [XLEN-1:0] wb_imm,
  input  logic            ex_ready,
  input  logic            flush,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_rdata1,
  output logic [XLEN-1:0] out_rdata2,
  output logic [XLEN-1:0] out_imm,
  output logic [AW-1:0]   out_rd,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic            out_funct7b5,
  output logic            out_is_load,
  output logic [31:0]     stall_cnt
);
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;
    logic [XLEN-1:0] imm;
    logic [AW-1:0]   rd;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic            is_load;
  } idex_t;

  logic [REG_COUNT-1:0][XLEN-1:0] r_rf;
  idex_t                          r_idex;
  logic                           r_vld;
  logic [31:0]                    r_stall;

  logic [XLEN-1:0]         w_wb_data;
  logic [1:0][AW-1:0]      w_rs;
  logic [1:0][XLEN-1:0]    w_rdata;
  logic [6:0]              w_op;
  logic [31:0]             w_imm32;
  logic [XLEN-1:0]         w_imm;
  logic                    w_use_rs1, w_use_rs2;
  logic                    w_hazard, w_advance;
  idex_t                   w_idex;

  // ---------------- write-back select and register file ----------------
  always_comb begin
    unique case (wb_sel)
      2'b00:   w_wb_data = wb_alu;
      2'b01:   w_wb_data = wb_mem;
      2'b10:   w_wb_data = wb_pc4;
      default: w_wb_data = wb_imm;
    endcase
  end

  // Writes are independent of the pipeline handshake: write-back is owned by
  // a later stage and must never be lost to a stall, flush or backpressure.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                           r_rf          <= '0;
    else if (wb_en && (wb_addr != '0))   r_rf[wb_addr] <= w_wb_data;
  end

  assign w_rs[0] = inst[15 +: AW];
  assign w_rs[1] = inst[20 +: AW];

  for (genvar g = 0; g < 2; g++) begin : g_rd
    decode_stage_rdport #(.XLEN(XLEN), .REG_COUNT(REG_COUNT), .AW(AW)) u_rd (
      .i_rf      (r_rf),
      .i_rs      (w_rs[g]),
      .i_wb_en   (wb_en),
      .i_wb_addr (wb_addr),
      .i_wb_data (w_wb_data),
      .o_rdata   (w_rdata[g])
    );
  end

  // ---------------- immediate generation ----------------
  assign w_op = inst[6:0];

  always_comb begin
    w_imm32 = '0;
    case (w_op)
      OP_IMM, OP_LOAD, OP_JALR:
        w_imm32 = {{20{inst[31]}}, inst[31:20]};
      OP_STORE:
        w_imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OP_BRANCH:
        w_imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        w_imm32 = {inst[31:12], 12'b0};
      OP_JAL:
        w_imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default:
        w_imm32 = '0;
    endcase
  end

  // Sign-extend to XLEN; the replication count stays >= 1 for XLEN = 32.
  assign w_imm = {{(XLEN-31){w_imm32[31]}}, w_imm32[30:0]};

  // ---------------- load-use interlock ----------------
  assign w_use_rs1 = !((w_op == OP_LUI) || (w_op == OP_AUIPC) || (w_op == OP_JAL));
  assign w_use_rs2 = (w_op == OP_OP) || (w_op == OP_STORE) || (w_op == OP_BRANCH);

  // The load result is not available until after execute/memory, so a
  // consumer directly behind a load gets one bubble.
  assign w_hazard = in_valid && r_vld && r_idex.is_load && (r_idex.rd != '0) &&
                    ((w_use_rs1 && (w_rs[0] == r_idex.rd)) ||
                     (w_use_rs2 && (w_rs[1] == r_idex.rd)));

  assign w_advance = !r_vld || ex_ready;
  assign in_ready  = w_advance && !w_hazard;

  // ---------------- ID/EX register ----------------
  always_comb begin
    w_idex          = '0;
    w_idex.pc       = pc;
    w_idex.rdata1   = w_rdata[0];
    w_idex.rdata2   = w_rdata[1];
    w_idex.imm      = w_imm;
    w_idex.rd       = inst[7 +: AW];
    w_idex.opcode   = w_op;
    w_idex.funct3   = inst[14:12];
    w_idex.funct7b5 = inst[30];
    w_idex.is_load  = (w_op == OP_LOAD);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_vld   <= 1'b0;
      r_idex  <= '0;
      r_stall <= '0;
    end else if (flush) begin
      r_vld <= 1'b0;
    end else if (w_advance) begin
      if (w_hazard) begin
        r_vld   <= 1'b0;
        r_stall <= r_stall + 32'd1;
      end else if (in_valid) begin
        r_vld  <= 1'b1;
        r_idex <= w_idex;
      end else begin
        r_vld <= 1'b0;
      end
    end
  end

  assign out_valid    = r_vld;
  assign out_pc       = r_idex.pc;
  assign out_rdata1   = r_idex.rdata1;
  assign out_rdata2   = r_idex.rdata2;
  assign out_imm      = r_idex.imm;
  assign out_rd       = r_idex.rd;
  assign out_opcode   = r_idex.opcode;
  assign out_funct3   = r_idex.funct3;
  assign out_funct7b5 = r_idex.funct7b5;
  assign out_is_load  = r_idex.is_load;
  assign stall_cnt    = r_stall;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  logic            clk, rstn;
  logic            in_valid, in_ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] pc;
  logic            wb_en;
  logic [AW-1:0]   wb_addr;
  logic [1:0]      wb_sel;
  logic [XLEN-1:0] wb_alu, wb_mem, wb_pc4, wb_imm;
  logic            ex_ready, flush;
  logic            out_valid;
  logic [XLEN-1:0] out_pc, out_rdata1, out_rdata2, out_imm;
  logic [AW-1:0]   out_rd;
  logic [6:0]      out_opcode;
  logic [2:0]      out_funct3;
  logic            out_funct7b5, out_is_load;
  logic [31:0]     stall_cnt;

  int checks   = 0;
  int failures = 0;

  decode_stage #(.XLEN(XLEN), .REG_COUNT(32)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .pc(pc), .wb_en(wb_en), .wb_addr(wb_addr), .wb_sel(wb_sel),
    .wb_alu(wb_alu), .wb_mem(wb_mem), .wb_pc4(wb_pc4), .wb_imm(wb_imm),
    .ex_ready(ex_ready), .flush(flush), .out_valid(out_valid),
    .out_pc(out_pc), .out_rdata1(out_rdata1), .out_rdata2(out_rdata2),
    .out_imm(out_imm), .out_rd(out_rd), .out_opcode(out_opcode),
    .out_funct3(out_funct3), .out_funct7b5(out_funct7b5),
    .out_is_load(out_is_load), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], OP_BRANCH};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
  endfunction

  initial begin
    logic [31:0] lw_x4;
    logic [31:0] add_dep;
    lw_x4   = enc_i(12'h000, 5'd1, 3'b010, 5'd4, OP_LOAD);
    add_dep = enc_r(7'h00, 5'd2, 5'd4, 3'b000, 5'd6, OP_OP);

    // ---- reset with random inputs ----
    rstn = 1'b1; flush = 1'b0;
    #1 rstn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'($urandom); inst = $urandom; pc = $urandom;
      wb_en = 1'($urandom); wb_addr = 5'($urandom); wb_sel = 2'($urandom);
      wb_alu = $urandom; wb_mem = $urandom; wb_pc4 = $urandom; wb_imm = $urandom;
      ex_ready = 1'($urandom); flush = 1'($urandom);
      tick();
    end
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk("rst_out_rd", 32'(out_rd), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    in_valid = 1'b1; ex_ready = 1'b1; flush = 1'b0; wb_en = 1'b0;
    wb_addr = '0; wb_sel = 2'b00; pc = 32'h0000_0100;
    wb_alu = 32'h1111_1111; wb_mem = 32'hAAAA_5555; wb_pc4 = 32'h2222_2222; wb_imm = 32'h3333_3333;
    inst = enc_r(7'h00, 5'd1, 5'd1, 3'b000, 5'd0, OP_OP);
    #2 rstn = 1'b1;

    // ---- every register reads zero after reset ----
    for (int k = 1; k < 32; k++) begin
      inst = enc_r(7'h00, 5'(k), 5'(k), 3'b000, 5'd0, OP_OP);
      tick();
      chk($sformatf("rst_x%0d_rs1", k), out_rdata1, 32'd0);
      chk($sformatf("rst_x%0d_rs2", k), out_rdata2, 32'd0);
    end

    // ---- same-cycle bypass then array read ----
    wb_en = 1'b1; wb_addr = 5'd5; wb_sel = 2'b00; wb_alu = 32'h0000_1234;
    inst = enc_r(7'h00, 5'd0, 5'd5, 3'b000, 5'd3, OP_OP);
    tick();
    chk("byp_rdata1", out_rdata1, 32'h0000_1234);
    chk("byp_rdata2", out_rdata2, 32'd0);
    chk("byp_rd", 32'(out_rd), 32'd3);
    chk("byp_valid", 32'(out_valid), 32'd1);
    wb_en = 1'b0; wb_alu = 32'h1111_1111;
    inst = enc_r(7'h00, 5'd5, 5'd0, 3'b000, 5'd3, OP_OP);
    tick();
    chk("arr_rdata2", out_rdata2, 32'h0000_1234);
    chk("arr_rdata1", out_rdata1, 32'd0);

    // ---- write-back source select ----
    inst = enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd0, OP_OP);
    wb_en = 1'b1; wb_addr = 5'd1; wb_sel = 2'b01; tick();
    wb_addr = 5'd2; wb_sel = 2'b10; tick();
    wb_addr = 5'd7; wb_sel = 2'b11; tick();
    wb_en = 1'b0;
    inst = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd0, OP_OP);
    tick();
    chk("sel_mem", out_rdata1, 32'hAAAA_5555);
    chk("sel_pc4", out_rdata2, 32'h2222_2222);
    inst = enc_r(7'h00, 5'd0, 5'd7, 3'b000, 5'd0, OP_OP);
    tick();
    chk("sel_imm", out_rdata1, 32'h3333_3333);

    // ---- x0 protection and immediates ----
    wb_en = 1'b1; wb_addr = 5'd0; wb_sel = 2'b00; wb_alu = 32'h0000_FFFF;
    inst = enc_i(12'hFFF, 5'd0, 3'b000, 5'd1, OP_IMM);
    tick();
    chk("x0_byp", out_rdata1, 32'd0);
    chk("imm_i_neg", out_imm, 32'hFFFF_FFFF);
    wb_en = 1'b0;
    inst = enc_i(12'h000, 5'd0, 3'b000, 5'd1, OP_IMM);
    tick();
    chk("x0_arr", out_rdata1, 32'd0);
    inst = {20'hABCDE, 5'd2, OP_LUI};
    tick();
    chk("imm_u", out_imm, 32'hABCD_E000);
    chk("lui_rd", 32'(out_rd), 32'd2);
    inst = enc_s(12'hFF8, 5'd4, 5'd1, 3'b010);
    tick();
    chk("imm_s", out_imm, 32'hFFFF_FFF8);
    chk("s_rdata1", out_rdata1, 32'hAAAA_5555);
    chk("s_funct3", 32'(out_funct3), 32'd2);
    inst = enc_b(13'h0800, 5'd0, 5'd0);
    tick();
    chk("imm_b_pos", out_imm, 32'h0000_0800);
    inst = enc_b(13'h1FFE, 5'd0, 5'd0);
    tick();
    chk("imm_b_neg", out_imm, 32'hFFFF_FFFE);
    inst = enc_j(21'h012346, 5'd1);
    tick();
    chk("imm_j_pos", out_imm, 32'h0001_2346);
    inst = enc_j(21'h1FFFFC, 5'd1);
    tick();
    chk("imm_j_neg", out_imm, 32'hFFFF_FFFC);
    inst = {25'h1FF_FFFF, 7'b0001111};
    tick();
    chk("imm_other", out_imm, 32'd0);
    pc = 32'h0000_0200;
    inst = enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd3, OP_OP);
    tick();
    chk("f7b5", 32'(out_funct7b5), 32'd1);
    chk("out_pc", out_pc, 32'h0000_0200);
    chk("not_load", 32'(out_is_load), 32'd0);

    // ---- load-use with R-type consumer ----
    inst = lw_x4;
    tick();
    chk("lw_is_load", 32'(out_is_load), 32'd1);
    inst = add_dep;
    #1 chk("lu_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("lu_bubble", 32'(out_valid), 32'd0);
    chk("lu_stall1", stall_cnt, 32'd1);
    chk("lu_ready_after", 32'(in_ready), 32'd1);
    tick();
    chk("lu_add_valid", 32'(out_valid), 32'd1);
    chk("lu_add_rd", 32'(out_rd), 32'd6);
    chk("lu_stall_hold", stall_cnt, 32'd1);

    // ---- load-use with store base conflict ----
    inst = lw_x4;
    tick();
    inst = enc_s(12'h000, 5'd2, 5'd4, 3'b010);
    #1 chk("sw_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("sw_bubble", 32'(out_valid), 32'd0);
    chk("sw_stall2", stall_cnt, 32'd2);
    tick();
    chk("sw_opcode", 32'(out_opcode), 32'(OP_STORE));

    // ---- fields that match but are not used: no stall ----
    inst = lw_x4;
    tick();
    inst = {20'h00020, 5'd7, OP_LUI};
    #1 chk("lui_no_haz", 32'(in_ready), 32'd1);
    tick();
    chk("lui_rd7", 32'(out_rd), 32'd7);
    inst = lw_x4;
    tick();
    inst = enc_i(12'h004, 5'd0, 3'b000, 5'd7, OP_IMM);
    #1 chk("addi_no_haz", 32'(in_ready), 32'd1);
    inst = enc_i(12'h000, 5'd1, 3'b010, 5'd0, OP_LOAD);
    tick();
    inst = enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd6, OP_OP);
    #1 chk("lw_x0_no_haz", 32'(in_ready), 32'd1);
    tick();
    chk("no_haz_stall", stall_cnt, 32'd2);

    // ---- backpressure ----
    inst = enc_i(12'h005, 5'd0, 3'b000, 5'd8, OP_IMM);
    tick();
    ex_ready = 1'b0;
    inst = enc_i(12'h007, 5'd0, 3'b000, 5'd9, OP_IMM);
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("bp_in_ready%0d", i), 32'(in_ready), 32'd0);
      tick();
      chk($sformatf("bp_rd%0d", i), 32'(out_rd), 32'd8);
      chk($sformatf("bp_imm%0d", i), out_imm, 32'd5);
      chk($sformatf("bp_valid%0d", i), 32'(out_valid), 32'd1);
    end
    ex_ready = 1'b1;
    tick();
    chk("bp_next_rd", 32'(out_rd), 32'd9);
    chk("bp_next_imm", out_imm, 32'd7);

    // ---- flush during load-use hazard ----
    inst = lw_x4;
    tick();
    inst = add_dep; flush = 1'b1;
    tick();
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_stall", stall_cnt, 32'd2);
    flush = 1'b0; in_valid = 1'b0;
    tick();
    chk("fl_not_captured", 32'(out_valid), 32'd0);
    chk("fl_stall_after", stall_cnt, 32'd2);

    // ---- asynchronous reset mid-stall ----
    in_valid = 1'b1; inst = lw_x4;
    tick();
    inst = add_dep;
    tick();
    chk("rs_stall3", stall_cnt, 32'd3);
    tick();
    inst = lw_x4;
    tick();
    inst = add_dep;
    #2 rstn = 1'b0;
    #1;
    chk("rs_async_valid", 32'(out_valid), 32'd0);
    chk("rs_async_stall", stall_cnt, 32'd0);
    chk("rs_async_rd", 32'(out_rd), 32'd0);
    inst = enc_r(7'h00, 5'd0, 5'd5, 3'b000, 5'd0, OP_OP);
    #1 rstn = 1'b1;
    tick();
    chk("rs_x5_cleared", out_rdata1, 32'd0);
    chk("rs_valid_after", 32'(out_valid), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
